// File: rtl/river_lane.sv
// One lane of NUM_PADS floating pads. The pads step left or right together every Speed+2
// enabled frames, wrap around the screen, and can cycle under water. A carry delta lets a rider follow the pads.
module river_lane #(
   parameter int NUM_PADS      = 4,
   parameter int PAD_W         = 40,
   parameter int PAD_H         = 40,
   parameter int SCREEN_W      = 640,
   parameter int STEP          = 40,
   parameter int X_TOL         = 10,
   parameter int Y_TOL         = 1,
   parameter int FROG_SIDE     = 40,
   parameter int DIVE_EN       = 0,
   parameter int SURFACE_MOVES = 6,
   parameter int DIVE_MOVES    = 2
) (
   input  logic                    frame_clk,
   input  logic                    Reset,
   input  logic                    Enable,
   input  logic [10:0]             Lane_Y,
   input  logic [10:0]             Start_X,
   input  logic [10:0]             Spacing,
   input  logic                    Direction,
   input  logic [4:0]              Speed,
   input  logic [10:0]             Frog_X,
   input  logic [10:0]             Frog_Y,
   output logic [12*NUM_PADS-1:0]  Pad_X,
   output logic [10:0]             Pad_Y,
   output logic [10:0]             Pad_Width,
   output logic [10:0]             Pad_Height,
   output logic [NUM_PADS-1:0]     Pad_Hit,
   output logic                    On_Pad,
   output logic                    Submerged,
   output logic                    Carry_Valid,
   output logic [11:0]             Carry_Dx,
   output logic                    dbg_state
);

   localparam int MC_TOTAL = SURFACE_MOVES + DIVE_MOVES;
   localparam int MC_W     = $clog2(MC_TOTAL + 1);

   localparam logic signed [11:0] STEP_S     = 12'(STEP);
   localparam logic signed [11:0] PAD_W_S    = 12'(PAD_W);
   localparam logic signed [11:0] SCREEN_W_S = 12'(SCREEN_W);
   localparam logic signed [11:0] WRAP_S     = 12'(SCREEN_W + PAD_W);
   localparam logic signed [13:0] PAD_W_C    = 14'(PAD_W);
   localparam logic signed [13:0] PAD_H_C    = 14'(PAD_H);
   localparam logic signed [13:0] X_TOL_C    = 14'(X_TOL);
   localparam logic signed [13:0] Y_TOL_C    = 14'(Y_TOL);
   localparam logic signed [13:0] SIDE_C     = 14'(FROG_SIDE);

   typedef enum logic {S_MOVE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic [4:0]               wait_cnt_q, wait_cnt_d;
   logic [MC_W-1:0]          move_cnt_q, move_cnt_d, mc_next;
   logic signed [11:0]       pad_x_q [NUM_PADS];
   logic signed [11:0]       pad_x_d [NUM_PADS];
   logic signed [11:0]       pad_init [NUM_PADS];
   logic signed [11:0]       nxt [NUM_PADS];
   logic [10:0]              pad_y_q, pad_y_d;
   logic                     sub_q, sub_d;
   logic                     cv_q, cv_d;
   logic signed [11:0]       dx_q, dx_d;
   logic                     do_move;
   logic signed [11:0]       step;
   logic signed [13:0]       fx, fy, cx0, cx1, cy0, cy1, py;
   logic signed [13:0]       px [NUM_PADS];
   logic                     y_in;

   always_ff @(posedge frame_clk) begin
      if (!Reset) begin
         state_q    <= S_MOVE;
         wait_cnt_q <= '0;
         move_cnt_q <= '0;
         pad_x_q    <= pad_init;
         pad_y_q    <= Lane_Y;
         sub_q      <= 1'b0;
         cv_q       <= 1'b0;
         dx_q       <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         move_cnt_q <= move_cnt_d;
         pad_x_q    <= pad_x_d;
         pad_y_q    <= pad_y_d;
         sub_q      <= sub_d;
         cv_q       <= cv_d;
         dx_q       <= dx_d;
      end
   end

   // Speed is compared live every WAIT cycle, so a change shortens or stretches the current wait.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      if (Enable) begin
         case (state_q)
            S_MOVE: begin
               state_d    = S_WAIT;
               wait_cnt_d = '0;
            end
            S_WAIT: begin
               if (wait_cnt_q == Speed) state_d = S_MOVE;
               else                     wait_cnt_d = wait_cnt_q + 5'd1;
            end
            default: state_d = S_MOVE;
         endcase
      end
   end

   // Carry_Valid is a single-cycle strobe with no back-pressure: the frog controller must
   // apply Carry_Dx in the same cycle it sees the strobe, which is the first cycle of new positions.
   always_comb begin
      do_move    = Enable && (state_q == S_MOVE);
      step       = Direction ? STEP_S : -STEP_S;
      mc_next    = move_cnt_q + MC_W'(1);
      pad_x_d    = pad_x_q;
      pad_y_d    = pad_y_q;
      move_cnt_d = move_cnt_q;
      sub_d      = sub_q;
      cv_d       = 1'b0;
      dx_d       = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         pad_init[i] = 12'({1'b0, Start_X}) + 12'(i) * 12'({1'b0, Spacing});
         nxt[i]      = pad_x_q[i] + step;
      end
      if (do_move) begin
         for (int i = 0; i < NUM_PADS; i++) begin
            if (nxt[i] <= -PAD_W_S)        pad_x_d[i] = nxt[i] + WRAP_S;
            else if (nxt[i] >= SCREEN_W_S) pad_x_d[i] = nxt[i] - WRAP_S;
            else                           pad_x_d[i] = nxt[i];
         end
         if (mc_next == MC_W'(MC_TOTAL)) begin
            move_cnt_d = '0;
            sub_d      = 1'b0;
         end else begin
            move_cnt_d = mc_next;
            sub_d      = (DIVE_EN != 0) && (mc_next >= MC_W'(SURFACE_MOVES));
         end
         cv_d = On_Pad;
         dx_d = On_Pad ? step : '0;
      end
   end

   // Collision uses 14-bit signed math so frog coordinates near 2047 cannot wrap.
   always_comb begin
      fx      = $signed({3'b000, Frog_X});
      fy      = $signed({3'b000, Frog_Y});
      cx0     = fx + X_TOL_C;
      cx1     = fx - X_TOL_C + SIDE_C;
      cy0     = fy + Y_TOL_C;
      cy1     = fy - Y_TOL_C + SIDE_C;
      py      = $signed({3'b000, pad_y_q});
      y_in    = ((cy0 >= py) && (cy0 <= py + PAD_H_C)) ||
                ((cy1 >= py) && (cy1 <= py + PAD_H_C));
      Pad_Hit = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         px[i]      = 14'(pad_x_q[i]);
         Pad_Hit[i] = y_in && (((cx0 >= px[i]) && (cx0 <= px[i] + PAD_W_C)) ||
                               ((cx1 >= px[i]) && (cx1 <= px[i] + PAD_W_C)));
      end
   end

   always_comb begin
      Pad_X = '0;
      for (int i = 0; i < NUM_PADS; i++) Pad_X[12*i +: 12] = pad_x_q[i];
      Pad_Y       = pad_y_q;
      Pad_Width   = 11'(PAD_W);
      Pad_Height  = 11'(PAD_H);
      On_Pad      = (|Pad_Hit) & ~sub_q;
      Submerged   = sub_q;
      Carry_Valid = cv_q;
      Carry_Dx    = dx_q;
      dbg_state   = state_q;
   end

endmodule

// File: tb/tb_river_lane.sv
// Bench for river_lane (4 pads, dive enabled): table of lane setups, a cycle model feeding a
// scoreboard queue, and hand sequences for freeze, carry, dive and mid-dive reset.
module tb_river_lane;
   localparam int NP = 4;

   logic              frame_clk = 1'b0;
   logic              Reset, Enable, Direction;
   logic [10:0]       Lane_Y, Start_X, Spacing, Frog_X, Frog_Y;
   logic [4:0]        Speed;
   logic [12*NP-1:0]  Pad_X;
   logic [10:0]       Pad_Y, Pad_Width, Pad_Height;
   logic [NP-1:0]     Pad_Hit;
   logic              On_Pad, Submerged, Carry_Valid, dbg_state;
   logic [11:0]       Carry_Dx;

   always #5 frame_clk = ~frame_clk;

   river_lane #(.NUM_PADS(NP), .DIVE_EN(1)) dut (
      .frame_clk(frame_clk), .Reset(Reset), .Enable(Enable), .Lane_Y(Lane_Y),
      .Start_X(Start_X), .Spacing(Spacing), .Direction(Direction), .Speed(Speed),
      .Frog_X(Frog_X), .Frog_Y(Frog_Y), .Pad_X(Pad_X), .Pad_Y(Pad_Y),
      .Pad_Width(Pad_Width), .Pad_Height(Pad_Height), .Pad_Hit(Pad_Hit),
      .On_Pad(On_Pad), .Submerged(Submerged), .Carry_Valid(Carry_Valid),
      .Carry_Dx(Carry_Dx), .dbg_state(dbg_state)
   );

   int n_pass = 0;
   int n_total = 0;
   logic [77:0] exp_q[$];

   int m_pad [NP];
   int m_ly, m_en, m_moves, m_dx;
   bit m_sub, m_cv;

   typedef struct {
      int          start_x, spacing, lane_y, speed, dir, frog_x, frog_y, ncyc;
      logic [47:0] exp_pads;
      logic        exp_cv;
      logic [11:0] exp_dx;
   } vec_t;
   vec_t vecs [5];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic bit corner_hit(input int p, input int ly, input int fx, input int fy);
      bit xin, yin;
      xin = ((fx + 10 >= p) && (fx + 10 <= p + 40)) || ((fx + 30 >= p) && (fx + 30 <= p + 40));
      yin = ((fy + 1 >= ly) && (fy + 1 <= ly + 40)) || ((fy + 39 >= ly) && (fy + 39 <= ly + 40));
      return xin && yin;
   endfunction

   task automatic model_step();
      logic [77:0] e;
      logic [47:0] pv;
      logic [3:0]  h;
      int d, n;
      bit op, eo;
      if (!Reset) begin
         m_ly = int'(Lane_Y);
         for (int i = 0; i < NP; i++) m_pad[i] = int'(Start_X) + i * int'(Spacing);
         m_en = 0; m_moves = 0; m_sub = 0; m_cv = 0; m_dx = 0;
      end else if (!Enable) begin
         m_cv = 0; m_dx = 0;
      end else begin
         if (m_en % (int'(Speed) + 2) == 0) begin
            d  = Direction ? 40 : -40;
            op = 0;
            for (int i = 0; i < NP; i++)
               if (corner_hit(m_pad[i], m_ly, int'(Frog_X), int'(Frog_Y))) op = 1;
            op   = op && !m_sub;
            m_cv = op;
            m_dx = op ? d : 0;
            for (int i = 0; i < NP; i++) begin
               n = m_pad[i] + d;
               if (n <= -40) n = n + 680;
               else if (n >= 640) n = n - 680;
               m_pad[i] = n;
            end
            m_moves++;
            m_sub = ((m_moves % 8) >= 6);
         end else begin
            m_cv = 0; m_dx = 0;
         end
         m_en++;
      end
      for (int i = 0; i < NP; i++) begin
         pv[12*i +: 12] = 12'(m_pad[i]);
         h[i] = corner_hit(m_pad[i], m_ly, int'(Frog_X), int'(Frog_Y));
      end
      eo = (|h) && !m_sub;
      e = {pv, 11'(m_ly), m_sub, m_cv, 12'(m_dx), h, eo};
      exp_q.push_back(e);
   endtask

   task automatic check_out();
      logic [77:0] e;
      if (exp_q.size() == 0) begin
         n_total++;
         $display("FAIL scoreboard_empty: got no expected entry");
         return;
      end
      e = exp_q.pop_front();
      chk("pad_x",     Pad_X,       e[77:30]);
      chk("pad_y",     Pad_Y,       e[29:19]);
      chk("submerged", Submerged,   e[18]);
      chk("carry_v",   Carry_Valid, e[17]);
      chk("carry_dx",  Carry_Dx,    e[16:5]);
      chk("pad_hit",   Pad_Hit,     e[4:1]);
      chk("on_pad",    On_Pad,      e[0]);
   endtask

   task automatic cycle();
      model_step();
      @(posedge frame_clk);
      #1;
      check_out();
   endtask

   task automatic setup(input int sx, input int sp, input int ly, input int spd, input int dir);
      Start_X = 11'(sx); Spacing = 11'(sp); Lane_Y = 11'(ly);
      Speed = 5'(spd); Direction = dir[0]; Enable = 1'b1;
      Reset = 1'b0;
      cycle();
      Reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cycles_to;
      bit moved;
      vecs[0] = '{100, 160, 200, 2, 1,   0, 500, 40, {12'd620, 12'd460, 12'd300, 12'd140}, 1'b0, 12'h000};
      vecs[1] = '{100, 160, 200, 0, 0, 110, 200, 40, {12'd540, 12'd380, 12'd220, 12'd60},  1'b1, 12'hFD8};
      vecs[2] = '{  0, 150, 100, 3, 0, 600, 100, 40, {12'd410, 12'd260, 12'd110, 12'd640}, 1'b0, 12'h000};
      vecs[3] = '{620,   0,  50, 1, 1, 620,  50, 40, {12'hFEC, 12'hFEC, 12'hFEC, 12'hFEC}, 1'b1, 12'h028};
      vecs[4] = '{ 10, 200, 300, 5, 1, 215, 300, 40, {12'hFE2, 12'd450, 12'd250, 12'd50},  1'b1, 12'h028};

      Reset = 1'b0; Enable = 1'b1; Direction = 1'b1; Speed = 5'd2;
      Lane_Y = 11'd200; Start_X = 11'd100; Spacing = 11'd160;
      Frog_X = 11'd0; Frog_Y = 11'd600;

      for (int v = 0; v < 5; v++) begin
         Frog_X = 11'(vecs[v].frog_x);
         Frog_Y = 11'(vecs[v].frog_y);
         setup(vecs[v].start_x, vecs[v].spacing, vecs[v].lane_y, vecs[v].speed, vecs[v].dir);
         chk($sformatf("vec%0d_rst_state", v), dbg_state, 1'b0);
         chk($sformatf("vec%0d_rst_cv", v), Carry_Valid, 1'b0);
         cycle();
         chk($sformatf("vec%0d_pads", v), Pad_X, vecs[v].exp_pads);
         chk($sformatf("vec%0d_cv", v), Carry_Valid, vecs[v].exp_cv);
         chk($sformatf("vec%0d_dx", v), Carry_Dx, vecs[v].exp_dx);
         for (int c = 0; c < vecs[v].ncyc; c++) cycle();
      end
      chk("pad_width", Pad_Width, 11'd40);
      chk("pad_height", Pad_Height, 11'd40);

      // Frog rides pad 0 through a full dive cycle, then reset lands mid-WAIT while submerged.
      Frog_Y = 11'd200; Frog_X = 11'd0;
      setup(100, 160, 200, 0, 1);
      chk("rst_pad_x", Pad_X, 48'h2441A4104064);
      for (int k = 0; k < 16; k++) begin
         Frog_X = 11'(m_pad[0] + 10);
         cycle();
         case (k)
            0:  begin chk("ride_cv", Carry_Valid, 1'b1); chk("ride_dx", Carry_Dx, 12'h028); end
            1:  begin chk("ride_cv_off", Carry_Valid, 1'b0); chk("ride_dx_off", Carry_Dx, 12'h000); end
            10: begin chk("dive_rise", Submerged, 1'b1); chk("dive_hit", Pad_Hit[0], 1'b1);
                      chk("dive_onpad", On_Pad, 1'b0); end
            12: begin chk("dive_nocarry", Carry_Valid, 1'b0); chk("dive_still", Submerged, 1'b1); end
            14: chk("dive_fall", Submerged, 1'b0);
            default: ;
         endcase
      end
      Frog_X = 11'd0; Frog_Y = 11'd600;
      for (int k = 0; k < 11; k++) cycle();
      chk("pre_rst_sub", Submerged, 1'b1);
      Reset = 1'b0;
      cycle();
      Reset = 1'b1;
      chk("midrst_pad_x", Pad_X, 48'h2441A4104064);
      chk("midrst_sub", Submerged, 1'b0);
      chk("midrst_pad_y", Pad_Y, 11'd200);

      // Freeze ten cycles mid-WAIT, then flip direction before the delayed move.
      setup(100, 160, 200, 2, 1);
      cycle();
      cycle();
      Enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk("freeze_pad0", Pad_X[11:0], 12'd140);
      end
      Enable = 1'b1;
      Direction = 1'b0;
      moved = 0;
      cycles_to = 0;
      for (int t = 0; t < 40 && !moved; t++) begin
         cycle();
         if (Pad_X[11:0] != 12'd140) begin
            moved = 1;
            cycles_to = t + 1;
         end
      end
      chk("freeze_delay", 64'(cycles_to), 64'd3);
      chk("dir_at_move", Pad_X[11:0], 12'd100);

      // Random direction, enable and frog position against the model.
      setup(40, 150, 200, 1, 1);
      for (int k = 0; k < 80; k++) begin
         Direction = 1'($urandom_range(0, 1));
         Enable    = ($urandom_range(0, 3) != 0);
         Frog_X    = 11'($urandom_range(0, 700));
         Frog_Y    = 11'($urandom_range(150, 260));
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/river_lane.md
Name: river_lane

Overview:
- Generalised successor to the single lilypad mover: one lane of NUM_PADS equally spaced floating pads sharing a Y row, step-moving left or right with a programmable frame delay between moves.
- Adds proper wrap-around, a pause input, optional periodic submerge ("dive") mode, and a per-move carry delta so the frog controller can ride the pads.
- Sits between the frame-clock domain game logic and the frog controller/sprite renderer.

Parameters:
- NUM_PADS, 4, number of pads in the lane (1..8).
- PAD_W, 40, pad width in pixels.
- PAD_H, 40, pad height in pixels.
- SCREEN_W, 640, visible width; wrap period = SCREEN_W + PAD_W.
- STEP, 40, pixels per move.
- X_TOL, 10, horizontal collision tolerance.
- Y_TOL, 1, vertical collision tolerance.
- FROG_SIDE, 40, frog sprite size.
- DIVE_EN, 0, 1 enables submerge cycling.
- SURFACE_MOVES, 6, moves spent surfaced per dive cycle.
- DIVE_MOVES, 2, moves spent submerged per dive cycle.

Ports:
- frame_clk  in  1  frame clock; all state on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Enable  in  1  1 = run; 0 = freeze all state.
- Lane_Y  in  11  lane top Y; latched at reset.
- Start_X  in  11  pad 0 X; latched at reset.
- Spacing  in  11  X distance between consecutive pads; latched at reset.
- Direction  in  1  0 = left, 1 = right; sampled in MOVE.
- Speed  in  5  WAIT length control.
- Frog_X, Frog_Y  in  11 each  frog top-left.
- Pad_X  out  12*NUM_PADS  signed X of pad i at bits [12*i +: 12].
- Pad_Y  out  11  latched Lane_Y.
- Pad_Width, Pad_Height  out  11 each  constants PAD_W, PAD_H.
- Pad_Hit  out  NUM_PADS  per-pad overlap flags (combinational).
- On_Pad  out  1  frog is standing on a surfaced pad (combinational).
- Submerged  out  1  lane currently dived.
- Carry_Valid  out  1  one-cycle pulse: frog must shift by Carry_Dx.
- Carry_Dx  out  12  signed carry delta.

Behaviour:
- Reset (Reset=0 at edge, regardless of Enable, including mid-WAIT or mid-dive):
  - state=MOVE, wait count=0, move count=0.
  - Pad_X[i] = Start_X + i*Spacing.
  - Pad_Y = Lane_Y.
  - Submerged=0, Carry_Valid=0, Carry_Dx=0.
  - Precondition: Start_X + (NUM_PADS-1)*Spacing < SCREEN_W.
- Enable=0: all registers hold; Carry_Valid forced 0 the next cycle.
- FSM states: MOVE, WAIT.
  - MOVE: one cycle → WAIT with count=0.
  - WAIT: count increments each cycle; when count==Speed, next state is MOVE.
  - Move period is Speed+2 enabled cycles.
- MOVE cycle updates (all pads in the same cycle), with d = -STEP if Direction=0, else +STEP, and n = Pad_X[i] + d:
  - Left wrap: if n <= -PAD_W, Pad_X[i] = n + SCREEN_W + PAD_W.
  - Right wrap: if n >= SCREEN_W, Pad_X[i] = n - SCREEN_W - PAD_W.
  - Otherwise Pad_X[i] = n.
  - All position arithmetic is 12-bit signed; no unsigned sentinel values.
- Dive (DIVE_EN=1 only; otherwise Submerged stays 0):
  - Move counter increments each MOVE and wraps at SURFACE_MOVES + DIVE_MOVES.
  - Submerged register is set when the post-increment count ≥ SURFACE_MOVES, cleared at wrap.
  - Submerged changes on the MOVE edge, together with positions.
- Collision (combinational from registered Pad_X/Pad_Y, signed compares, closed intervals):
  - Pad_Hit[i]=1 if any frog test corner lies in [Pad_X[i], Pad_X[i]+PAD_W] × [Pad_Y, Pad_Y+PAD_H].
  - Test corners: (Frog_X+X_TOL, Frog_Y+Y_TOL), (Frog_X+X_TOL, Frog_Y-Y_TOL+FROG_SIDE), (Frog_X-X_TOL+FROG_SIDE, Frog_Y+Y_TOL), (Frog_X-X_TOL+FROG_SIDE, Frog_Y-Y_TOL+FROG_SIDE).
  - On_Pad = (|Pad_Hit) & ~Submerged.
  - Pad_Hit is reported even when submerged.
- Carry:
  - On the MOVE edge, Carry_Valid <= On_Pad, using pre-move positions; Carry_Dx <= d if On_Pad, else 0.
  - Every other edge: Carry_Valid <= 0, Carry_Dx <= 0.
  - Latency: pulse is aligned with the first cycle showing the new positions.
- Simultaneous events:
  - Reset overrides Enable and everything else.
  - A Direction change during WAIT takes effect at the next MOVE only.
  - The Speed value compared is the live input each WAIT cycle.

Test Plan:
- Reset with Start_X=100, Spacing=160, NUM_PADS=4, Speed=2, Direction=1 → Pad_X={100,260,420,580}, Carry_Valid=0; MOVEs at enabled cycles 0, 4, 8, ...; after first MOVE Pad_X={140,300,460,620}.
- Right wrap: pad at 620, Direction=1 → next MOVE gives 660 ≥ 640 → -20; left wrap: pad at 0, Direction=0 → -40 ≤ -40 → 640.
- Frog_X=110, Frog_Y=Lane_Y, pad at 100, Direction=0 → On_Pad=1; one cycle after MOVE: Carry_Valid=1, Carry_Dx=-40 (0xFD8), then 0 the next cycle.
- DIVE_EN=1, SURFACE_MOVES=6, DIVE_MOVES=2 → Submerged rises on MOVE #6, falls on MOVE #8; frog on pad while submerged → Pad_Hit=1, On_Pad=0, no carry pulse.
- Enable=0 for 10 cycles mid-WAIT → positions and count frozen, MOVE delayed by exactly 10 cycles; Reset=0 asserted mid-WAIT with Submerged=1 → next cycle shows initial positions and Submerged=0.
